// File: rtl/io_pkg.sv
// io_pkg: register offsets, status/command bit positions and FSM states for mmio_io_ctrl
package io_pkg;
    localparam logic [1:0] KB_STAT = 2'd0, KB_DATA = 2'd1, TTY_STAT = 2'd2, TTY_DATA = 2'd3;
    localparam int RX_NONEMPTY_BIT = 0, RX_FULL_BIT = 1;
    localparam int TX_NOT_FULL_BIT = 0, TX_DROP_BIT = 1, TX_EMPTY_BIT = 2;
    localparam int CMD_FLUSH_BIT = 0, CMD_DROP_CLR_BIT = 1;
    typedef enum logic [1:0] {K_IDLE, K_CAPT, K_ACK, K_WAIT} kb_state_t;
    typedef enum logic [1:0] {T_IDLE, T_SEND, T_WAIT} tty_state_t;
endpackage

// File: rtl/mmio_io_ctrl_if.sv
// mmio_io_ctrl_if: CPU memory-port signals seen by the I/O window
interface mmio_io_ctrl_if;
    logic [31:0] addr;
    logic [7:0]  data_in;
    logic [7:0]  data_out;
    logic        RAM_use;
    logic        RAM_read;
    logic        RAM_write;
    logic        io_hit;
    modport master (output addr, data_in, RAM_use, RAM_read, RAM_write, input data_out, io_hit);
    modport slave  (input addr, data_in, RAM_use, RAM_read, RAM_write, output data_out, io_hit);
endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with count; flush beats push/pop, push into a full FIFO needs a pop
module sync_fifo #(
    parameter int WIDTH = 7,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             full,
    output logic [AW:0]      count
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic do_push, do_pop;
    assign empty   = count == '0;
    assign full    = count == (AW+1)'(DEPTH);
    assign do_pop  = pop & !empty;
    assign do_push = push & (!full | do_pop);
    assign head    = mem[rd_ptr];
    always_ff @(posedge clk) begin
        if (reset | flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/mmio_io_ctrl.sv
// mmio_io_ctrl: 16-byte I/O window bridging the CPU bus to a keyboard and a TTY through FIFOs
module mmio_io_ctrl
    import io_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h00fffe00,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    mmio_io_ctrl_if.slave        bus,
    input  logic                 KB_status,
    input  logic [6:0]           KB_data,
    output logic                 KB_read_en,
    output logic                 KB_clear,
    input  logic                 TTY_ready,
    output logic [6:0]           TTY_data,
    output logic                 TTY_en,
    output logic                 TTY_clear
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    kb_state_t  k_state;
    tty_state_t t_state;
    logic access, access_q, first, rd, wr, drop;
    logic [1:0] sel;
    logic [7:0] kb_stat, tty_stat, rd_val;
    logic rx_push, rx_pop, rx_empty, rx_full, tx_push, tx_pop, tx_flush, tx_empty, tx_full;
    logic [6:0] rx_head, tx_head;
    logic [CW-1:0] rx_count, tx_count;
    logic unused;
    assign unused = &{1'b0, bus.addr[1:0], bus.data_in[7], rx_count, tx_count};
    assign bus.io_hit = bus.addr[31:4] == BASE_ADDR[31:4];
    assign access = bus.RAM_use & bus.io_hit & (bus.RAM_read | bus.RAM_write);
    // Side effects only on the leading cycle so a held strobe acts once
    assign first = access & !access_q;
    assign rd    = first & bus.RAM_read;
    assign wr    = first & bus.RAM_write & !bus.RAM_read;
    assign sel   = bus.addr[3:2];
    assign rx_push  = k_state == K_CAPT;
    assign rx_pop   = rd & sel == KB_DATA;
    assign tx_push  = wr & sel == TTY_DATA & !tx_full;
    assign tx_pop   = t_state == T_SEND;
    assign tx_flush = wr & sel == TTY_STAT & bus.data_in[CMD_FLUSH_BIT];
    always_comb begin
        kb_stat  = '0;
        tty_stat = '0;
        kb_stat[RX_NONEMPTY_BIT]  = !rx_empty;
        kb_stat[RX_FULL_BIT]      = rx_full;
        tty_stat[TX_NOT_FULL_BIT] = !tx_full;
        tty_stat[TX_DROP_BIT]     = drop;
        tty_stat[TX_EMPTY_BIT]    = tx_empty;
        rd_val = sel == KB_STAT  ? kb_stat :
                 sel == KB_DATA  ? (rx_empty ? 8'h00 : {1'b0, rx_head}) :
                 sel == TTY_STAT ? tty_stat : 8'h00;
    end
    sync_fifo #(.WIDTH(7), .DEPTH(FIFO_DEPTH)) u_rx (
        .clk(clk), .reset(reset), .push(rx_push), .pop(rx_pop), .flush(1'b0), .din(KB_data),
        .head(rx_head), .empty(rx_empty), .full(rx_full), .count(rx_count));
    sync_fifo #(.WIDTH(7), .DEPTH(FIFO_DEPTH)) u_tx (
        .clk(clk), .reset(reset), .push(tx_push), .pop(tx_pop), .flush(tx_flush), .din(bus.data_in[6:0]),
        .head(tx_head), .empty(tx_empty), .full(tx_full), .count(tx_count));
    always_ff @(posedge clk) begin
        if (reset) begin
            access_q     <= 1'b0;
            bus.data_out <= '0;
            drop         <= 1'b0;
            TTY_clear    <= 1'b0;
            k_state      <= K_IDLE;
            KB_read_en   <= 1'b0;
            KB_clear     <= 1'b0;
            t_state      <= T_IDLE;
            TTY_en       <= 1'b0;
            TTY_data     <= '0;
        end else begin
            access_q   <= access;
            TTY_clear  <= tx_flush;
            KB_read_en <= 1'b0;
            KB_clear   <= 1'b0;
            TTY_en     <= 1'b0;
            if (rd) bus.data_out <= rd_val;
            if (wr & sel == TTY_DATA & tx_full) drop <= 1'b1;
            else if (wr & sel == TTY_STAT & bus.data_in[CMD_DROP_CLR_BIT]) drop <= 1'b0;
            case (k_state)
                K_IDLE: if (KB_status & !rx_full) begin
                    k_state    <= K_CAPT;
                    KB_read_en <= 1'b1;
                end
                K_CAPT: begin
                    k_state  <= K_ACK;
                    KB_clear <= 1'b1;
                end
                K_ACK:   k_state <= K_WAIT;
                default: if (!KB_status) k_state <= K_IDLE;
            endcase
            // A flush aborts the handshake and must not launch a stale head
            if (tx_flush) t_state <= T_IDLE;
            else case (t_state)
                T_IDLE: if (!tx_empty & TTY_ready) begin
                    t_state  <= T_SEND;
                    TTY_en   <= 1'b1;
                    TTY_data <= tx_head;
                end
                T_SEND:  t_state <= T_WAIT;
                default: if (!TTY_ready) t_state <= T_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mmio_io_ctrl.sv
// tb_mmio_io_ctrl: directed scenarios for the keyboard/TTY I/O window
module tb_mmio_io_ctrl;
    logic clk = 1'b0;
    logic reset, KB_status, TTY_ready;
    logic [6:0] KB_data, TTY_data;
    logic KB_read_en, KB_clear, TTY_en, TTY_clear;
    logic [7:0] d;
    int n_cmp = 0, n_fail = 0;
    int rd_en_cnt = 0, clr_cnt = 0, en_cnt = 0, tclr_cnt = 0;
    logic [6:0] tty_log [$];

    mmio_io_ctrl_if bus();
    mmio_io_ctrl dut (
        .clk(clk), .reset(reset), .bus(bus),
        .KB_status(KB_status), .KB_data(KB_data), .KB_read_en(KB_read_en), .KB_clear(KB_clear),
        .TTY_ready(TTY_ready), .TTY_data(TTY_data), .TTY_en(TTY_en), .TTY_clear(TTY_clear));

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (KB_read_en) rd_en_cnt++;
        if (KB_clear) clr_cnt++;
        if (TTY_clear) tclr_cnt++;
        if (TTY_en) begin
            en_cnt++;
            tty_log.push_back(TTY_data);
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_idle();
        bus.RAM_use = 1'b0;
        bus.RAM_read = 1'b0;
        bus.RAM_write = 1'b0;
    endtask

    task automatic cpu_read(input logic [31:0] a, output logic [7:0] v);
        bus.addr = a;
        bus.RAM_use = 1'b1;
        bus.RAM_read = 1'b1;
        bus.RAM_write = 1'b0;
        step(1);
        v = bus.data_out;
        bus_idle();
        step(1);
    endtask

    task automatic cpu_write(input logic [31:0] a, input logic [7:0] v);
        bus.addr = a;
        bus.data_in = v;
        bus.RAM_use = 1'b1;
        bus.RAM_write = 1'b1;
        bus.RAM_read = 1'b0;
        step(1);
        bus_idle();
        step(1);
    endtask

    task automatic kb_char(input logic [6:0] c);
        int k;
        KB_data = c;
        KB_status = 1'b1;
        for (k = 0; k < 12 && !KB_clear; k++) step(1);
        n_cmp++;
        if (!KB_clear) begin
            n_fail++;
            $display("FAIL kb_char_ack: KB_clear=%b required 1 within 12 cycles", KB_clear);
        end
        KB_status = 1'b0;
        step(2);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        KB_status = 1'b0;
        KB_data = '0;
        TTY_ready = 1'b0;
        bus.addr = '0;
        bus.data_in = '0;
        bus_idle();
        step(3);
        n_cmp++;
        if ({KB_read_en, KB_clear, TTY_en, TTY_clear, TTY_data, bus.data_out} !== 19'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h required 0", {KB_read_en, KB_clear, TTY_en, TTY_clear, TTY_data, bus.data_out});
        end
        reset = 1'b0;
        bus.addr = 32'h00fffe0c;
        #1;
        n_cmp++;
        if (bus.io_hit !== 1'b1) begin
            n_fail++;
            $display("FAIL io_hit_top: got %b required 1", bus.io_hit);
        end
        bus.addr = 32'h00fffe10;
        #1;
        n_cmp++;
        if (bus.io_hit !== 1'b0) begin
            n_fail++;
            $display("FAIL io_hit_above: got %b required 0", bus.io_hit);
        end
        bus.addr = 32'h00fffdfc;
        #1;
        n_cmp++;
        if (bus.io_hit !== 1'b0) begin
            n_fail++;
            $display("FAIL io_hit_below: got %b required 0", bus.io_hit);
        end
        cpu_read(32'h00fffe00, d);
        n_cmp++;
        if (d !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_kb_stat: got %h required 00", d);
        end
        cpu_read(32'h00fffe08, d);
        n_cmp++;
        if (d !== 8'h05) begin
            n_fail++;
            $display("FAIL reset_tty_stat: got %h required 05", d);
        end
    endtask

    task automatic test_keyboard();
        int rb = rd_en_cnt, cb = clr_cnt, k;
        KB_data = 7'h07;
        KB_status = 1'b1;
        for (k = 0; k < 8 && !KB_read_en; k++) step(1);
        step(1);
        n_cmp++;
        if ({KB_read_en, KB_clear} !== 2'b01) begin
            n_fail++;
            $display("FAIL kb_order: read_en,clear got %b required 01", {KB_read_en, KB_clear});
        end
        step(3);
        KB_status = 1'b0;
        step(2);
        n_cmp++;
        if (rd_en_cnt - rb != 1 || clr_cnt - cb != 1) begin
            n_fail++;
            $display("FAIL kb_pulses: read_en=%0d clear=%0d required 1 and 1", rd_en_cnt - rb, clr_cnt - cb);
        end
        kb_char(7'h09);
        bus.addr = 32'h00fffe04;
        bus.RAM_use = 1'b1;
        bus.RAM_read = 1'b1;
        step(1);
        n_cmp++;
        if (bus.data_out !== 8'h07) begin
            n_fail++;
            $display("FAIL kb_held_first: got %h required 07", bus.data_out);
        end
        step(2);
        n_cmp++;
        if (bus.data_out !== 8'h07) begin
            n_fail++;
            $display("FAIL kb_held_last: got %h required 07", bus.data_out);
        end
        bus_idle();
        step(1);
        cpu_read(32'h00fffe00, d);
        n_cmp++;
        if (d !== 8'h01) begin
            n_fail++;
            $display("FAIL kb_single_pop: status got %h required 01", d);
        end
        cpu_read(32'h00fffe04, d);
        n_cmp++;
        if (d !== 8'h09) begin
            n_fail++;
            $display("FAIL kb_second_char: got %h required 09", d);
        end
        cpu_read(32'h00fffe04, d);
        n_cmp++;
        if (d !== 8'h00) begin
            n_fail++;
            $display("FAIL kb_empty_read: got %h required 00", d);
        end
    endtask

    task automatic test_tty_drop();
        int eb = en_cnt, lb = tty_log.size();
        TTY_ready = 1'b0;
        for (int i = 0; i < 5; i++) cpu_write(32'h00fffe0c, 8'(8'h41 + i));
        cpu_read(32'h00fffe08, d);
        n_cmp++;
        if (d !== 8'h02) begin
            n_fail++;
            $display("FAIL tty_full_drop: status got %h required 02", d);
        end
        n_cmp++;
        if (en_cnt != eb) begin
            n_fail++;
            $display("FAIL tty_not_ready: TTY_en count got %0d required 0", en_cnt - eb);
        end
        repeat (10) begin
            TTY_ready = 1'b1;
            step(2);
            TTY_ready = 1'b0;
            step(2);
        end
        n_cmp++;
        if (en_cnt - eb != 4) begin
            n_fail++;
            $display("FAIL tty_send_count: got %0d required 4", en_cnt - eb);
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (tty_log.size() <= lb + i || tty_log[lb + i] !== 7'(8'h41 + i)) begin
                n_fail++;
                $display("FAIL tty_char%0d: got %h required %h", i, tty_log.size() > lb + i ? tty_log[lb + i] : 7'h7f, 7'(8'h41 + i));
            end
        end
        cpu_read(32'h00fffe08, d);
        n_cmp++;
        if (d !== 8'h07) begin
            n_fail++;
            $display("FAIL tty_drained: status got %h required 07", d);
        end
    endtask

    task automatic test_flush();
        int tb0, eb;
        TTY_ready = 1'b0;
        cpu_write(32'h00fffe0c, 8'h50);
        cpu_write(32'h00fffe0c, 8'h51);
        cpu_read(32'h00fffe08, d);
        n_cmp++;
        if (d !== 8'h03) begin
            n_fail++;
            $display("FAIL flush_pre: status got %h required 03", d);
        end
        tb0 = tclr_cnt;
        cpu_write(32'h00fffe08, 8'h03);
        n_cmp++;
        if (tclr_cnt - tb0 != 1) begin
            n_fail++;
            $display("FAIL flush_clear_pulse: got %0d cycles required 1", tclr_cnt - tb0);
        end
        cpu_read(32'h00fffe08, d);
        n_cmp++;
        if (d !== 8'h05) begin
            n_fail++;
            $display("FAIL flush_post: status got %h required 05", d);
        end
        eb = en_cnt;
        TTY_ready = 1'b1;
        step(8);
        TTY_ready = 1'b0;
        n_cmp++;
        if (en_cnt != eb) begin
            n_fail++;
            $display("FAIL flush_no_send: TTY_en count got %0d required 0", en_cnt - eb);
        end
    endtask

    task automatic test_back_to_back();
        int rb, k;
        kb_char(7'h11);
        kb_char(7'h12);
        KB_data = 7'h13;
        KB_status = 1'b1;
        for (k = 0; k < 8 && !KB_read_en; k++) step(1);
        bus.addr = 32'h00fffe04;
        bus.RAM_use = 1'b1;
        bus.RAM_read = 1'b1;
        step(1);
        bus_idle();
        n_cmp++;
        if (bus.data_out !== 8'h11) begin
            n_fail++;
            $display("FAIL b2b_pop: got %h required 11", bus.data_out);
        end
        step(2);
        KB_status = 1'b0;
        step(2);
        cpu_read(32'h00fffe00, d);
        n_cmp++;
        if (d !== 8'h01) begin
            n_fail++;
            $display("FAIL b2b_count2: status got %h required 01", d);
        end
        kb_char(7'h14);
        kb_char(7'h15);
        cpu_read(32'h00fffe00, d);
        n_cmp++;
        if (d !== 8'h03) begin
            n_fail++;
            $display("FAIL b2b_full: status got %h required 03", d);
        end
        rb = rd_en_cnt;
        KB_data = 7'h16;
        KB_status = 1'b1;
        step(5);
        n_cmp++;
        if (rd_en_cnt != rb) begin
            n_fail++;
            $display("FAIL b2b_backpressure: read_en count got %0d required 0", rd_en_cnt - rb);
        end
        cpu_read(32'h00fffe04, d);
        n_cmp++;
        if (d !== 8'h12) begin
            n_fail++;
            $display("FAIL b2b_order0: got %h required 12", d);
        end
        for (k = 0; k < 10 && !KB_clear; k++) step(1);
        KB_status = 1'b0;
        step(2);
        n_cmp++;
        if (rd_en_cnt - rb != 1) begin
            n_fail++;
            $display("FAIL b2b_resume: read_en count got %0d required 1", rd_en_cnt - rb);
        end
        for (int i = 0; i < 4; i++) begin
            cpu_read(32'h00fffe04, d);
            n_cmp++;
            if (d !== 8'(8'h13 + i)) begin
                n_fail++;
                $display("FAIL b2b_wrap%0d: got %h required %h", i, d, 8'(8'h13 + i));
            end
        end
        cpu_read(32'h00fffe04, d);
        n_cmp++;
        if (d !== 8'h00) begin
            n_fail++;
            $display("FAIL b2b_empty: got %h required 00", d);
        end
    endtask

    task automatic test_reset_mid();
        int k;
        TTY_ready = 1'b0;
        cpu_write(32'h00fffe0c, 8'h2a);
        TTY_ready = 1'b1;
        for (k = 0; k < 8 && !TTY_en; k++) step(1);
        n_cmp++;
        if (TTY_en !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_send_reach: TTY_en got %b required 1", TTY_en);
        end
        reset = 1'b1;
        TTY_ready = 1'b0;
        step(1);
        n_cmp++;
        if ({TTY_en, TTY_clear, TTY_data} !== 9'h0) begin
            n_fail++;
            $display("FAIL mid_send_reset: got %h required 0", {TTY_en, TTY_clear, TTY_data});
        end
        reset = 1'b0;
        step(1);
        cpu_read(32'h00fffe08, d);
        n_cmp++;
        if (d !== 8'h05) begin
            n_fail++;
            $display("FAIL mid_send_tx_empty: status got %h required 05", d);
        end
        KB_data = 7'h33;
        KB_status = 1'b1;
        for (k = 0; k < 8 && !KB_clear; k++) step(1);
        reset = 1'b1;
        KB_status = 1'b0;
        step(1);
        n_cmp++;
        if ({KB_read_en, KB_clear, bus.data_out} !== 10'h0) begin
            n_fail++;
            $display("FAIL mid_ack_reset: got %h required 0", {KB_read_en, KB_clear, bus.data_out});
        end
        reset = 1'b0;
        step(1);
        cpu_read(32'h00fffe00, d);
        n_cmp++;
        if (d !== 8'h00) begin
            n_fail++;
            $display("FAIL mid_ack_rx_empty: status got %h required 00", d);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_keyboard();
        test_tty_drop();
        test_flush();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/mmio_io_ctrl.md
# mmio_io_ctrl

Memory-mapped I/O controller between the Y86 CPU memory port and the keyboard/TTY devices. It decodes the 16-byte I/O window, buffers keyboard characters and TTY output in two small FIFOs, and runs the device handshakes so the CPU never stalls on device timing. It sits in parallel with RAM on the data bus; `io_hit` steers the read mux.

## Interface
- `BASE_ADDR`, default 32'h00fffe00: base of the I/O window, 16-byte aligned.
- `FIFO_DEPTH`, default 4: entries per FIFO, power of two, at least 2.

Ports:
- `clk` in 1: single clock; all state updates on rising edge.
- `reset` in 1: synchronous, active-high.
- `addr` in 32: CPU byte address.
- `data_in` in 8: CPU write data.
- `RAM_use` in 1: bus access qualifier.
- `RAM_read` in 1: read strobe.
- `RAM_write` in 1: write strobe.
- `data_out` out 8: registered read data.
- `io_hit` out 1: combinational; asserted when `addr[31:4] == BASE_ADDR[31:4]`.
- `KB_status` in 1: keyboard holds a character.
- `KB_data` in 7: keyboard character.
- `KB_read_en` out 1: one-cycle capture pulse to keyboard.
- `KB_clear` out 1: one-cycle acknowledge to keyboard.
- `TTY_ready` in 1: TTY can accept a character.
- `TTY_data` out 7: character to TTY.
- `TTY_en` out 1: one-cycle write strobe to TTY.
- `TTY_clear` out 1: one-cycle TTY clear pulse.

## Operation
- Access = `RAM_use & io_hit & (RAM_read | RAM_write)`. Read wins if both strobes are set. Side effects fire only on the first cycle of an access (access & !access_q); a held access acts once.
- Register map by `addr[3:2]` (`addr[1:0]` ignored):
  - 0, KB status, RO: {6'b0, rx_full, rx_nonempty}.
  - 1, KB data, RO: {1'b0, rx head}; pops rx. If rx is empty, returns 8'h00 with no pop.
  - 2, TTY status, R/W.
    - Read: {5'b0, tx_empty, drop, tx_not_full}.
    - Write: `data_in[0]=1` flushes tx and pulses `TTY_clear`; `data_in[1]=1` clears `drop`.
  - 3, TTY data, WO: pushes `data_in[6:0]` into tx. If tx is full, the write is discarded and sticky `drop` is set. A read returns 8'h00.
- Writes to RO registers are ignored.
- Keyboard FSM:
  - K_IDLE → K_CAPT when `KB_status & !rx_full`.
  - K_CAPT: `KB_read_en`=1; on exit, push `KB_data` to rx.
  - K_ACK: `KB_clear`=1.
  - K_WAIT: stay until `KB_status`=0, then → K_IDLE.
  - While rx is full, the FSM stays in K_IDLE (backpressure; no loss).
- TTY FSM:
  - T_IDLE → T_SEND when `!tx_empty & TTY_ready`.
  - T_SEND: `TTY_en`=1 and `TTY_data`=tx head; pop tx on exit.
  - T_WAIT: stay until `TTY_ready`=0, then → T_IDLE.
  - A flush in T_SEND or T_WAIT forces T_IDLE next cycle. A character already strobed is not recalled.
- Simultaneous push and pop on one FIFO: both take effect, count unchanged. A pop on the last entry together with a push leaves count 1. Pointers wrap modulo `FIFO_DEPTH`; count is log2(DEPTH)+1 bits wide.
- Flush and push in the same cycle: flush wins; FIFO ends empty.

## Timing
- Reset (synchronous; overrides every other event that cycle):
  - All outputs 0; `TTY_data`=0.
  - FIFOs empty, `drop`=0, FSMs in IDLE, `access_q`=0.
- Read latency 1: `data_out` is loaded at the edge ending the first access cycle and holds until the next read access. The pop happens at the same edge.
- Write latency 1: FIFO and status state update at the edge ending the first access cycle.
- `io_hit` has zero latency (combinational).
- Keyboard: `KB_read_en` rises 1 cycle after `KB_status` is sampled high; the character is in rx 1 cycle later; `KB_clear` follows. A CPU status read sees `rx_nonempty` on the read issued after the push edge.
- TTY: `TTY_en` is asserted for exactly 1 cycle. The next character goes out no earlier than 2 cycles after `TTY_ready` returns high.

## Structure
- Package `io_pkg`:
  - Register offsets: KB_STAT=0, KB_DATA=1, TTY_STAT=2, TTY_DATA=3.
  - Status bit indices.
  - Keyboard and TTY state enums.
- Sub-module `sync_fifo` (params WIDTH, DEPTH; push, pop, flush, head, empty, full, count), instantiated twice at width 7. Both FSMs and the decoder stay in `mmio_io_ctrl`.

## Test plan
- Reset, then idle: all outputs 0; a read of 0x00fffe00 returns 8'h00; a read of 0x00fffe08 returns 8'h05.
- `KB_status`=1 with `KB_data`=7'h07: `KB_read_en` then `KB_clear` pulse once each. A read of 0x00fffe04 held 3 cycles returns 8'h07 and pops once; a second read returns 8'h00.
- Five writes of 8'h41..8'h45 to 0x00fffe0c with `TTY_ready`=0: four entries queued; status reads 8'h02 (drop set, full). Then `TTY_ready` toggles; `TTY_en` fires four times with 7'h41..7'h44.
- Write 8'h03 to 0x00fffe08 while tx holds 2 entries: `TTY_clear` pulses 1 cycle; tx empties; `drop` clears; no further `TTY_en`.
- Keyboard push and CPU pop of rx in the same cycle at count 2: count stays 2; FIFO order is preserved across pointer wrap.
- `reset` asserted mid-T_SEND and mid-K_ACK: the next cycle shows all outputs 0 and FIFOs empty.
